// File: rtl/window_pkg.sv
// Shared helpers for the K x K window generator and the filter cores that read its taps.
package window_pkg;

    // Counter/address width for a range of n values; a single-entry range still needs one bit.
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of tap (r,c) inside a flattened K x K window of CH channels of width bits each.
    function automatic int tap_lsb(input int r, input int c, input int k, input int ch, input int width);
        return ((r * k) + c) * ch * width;
    endfunction

    // The window edge must be 2..7 and must fit inside the frame in both directions.
    function automatic bit params_legal(input int k, input int col_num, input int row_num);
        return (k >= 2) && (k <= 7) && (k <= col_num) && (k <= row_num);
    endfunction

endpackage

// File: rtl/line_ram.sv
// One video line of storage: simple dual-port, synchronous read, contents never reset.
module line_ram
    import window_pkg::*;
#(
    parameter  int DEPTH = 1280,
    parameter  int WIDTH = 8,
    localparam int AW    = CNT_W(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; a read at the written address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/window_kxk_gen.sv
// K x K sliding-window generator: K-1 line memories feed a K x K tap register, and only
// windows that lie completely inside the current frame are presented downstream.
module window_kxk_gen
    import window_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CH      = 1,
    parameter int K       = 3,
    parameter int COL_NUM = 1280,
    parameter int ROW_NUM = 720
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     sof,
    input  logic [CH*WIDTH-1:0]      din,
    output logic                     win_valid,
    output logic [K*K*CH*WIDTH-1:0]  win_data,
    output logic                     win_sof,
    output logic                     win_eol,
    output logic                     win_eof
);

    localparam int PW = CH * WIDTH;
    localparam int CW = CNT_W(COL_NUM);
    localparam int RW = CNT_W(ROW_NUM);

    localparam logic [CW-1:0] COL_LAST  = CW'(COL_NUM - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_NUM - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    if (!params_legal(K, COL_NUM, ROW_NUM)) begin : g_illegal_params
        $error("window_kxk_gen: K=%0d is illegal for COL_NUM=%0d ROW_NUM=%0d", K, COL_NUM, ROW_NUM);
    end

    logic [CW-1:0] col_cnt, pix_col, next_col;
    logic [RW-1:0] row_cnt, pix_row, next_row;
    logic          pix_qual, pix_first, pix_eol, pix_eof;

    logic          s1_valid, s1_qual, s1_first, s1_eol, s1_eof;
    logic [CW-1:0] s1_col;
    logic [PW-1:0] s1_pix;

    logic          s2_valid, s2_first, s2_eol, s2_eof;
    logic [K*K*PW-1:0] tap;

    logic [PW-1:0] ram_q   [K-1];
    logic [PW-1:0] col_vec [K];

    // Position of the pixel on the input this cycle (sof forces 0,0) and where the raster goes next.
    always_comb begin
        pix_col  = sof ? '0 : col_cnt;
        pix_row  = sof ? '0 : row_cnt;
        next_col = pix_col + CW'(1);
        next_row = pix_row;
        if (pix_col == COL_LAST) begin
            next_col = '0;
            next_row = (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
        end
        pix_qual  = (pix_row >= ROW_FIRST) && (pix_col >= COL_FIRST);
        pix_first = (pix_row == ROW_FIRST) && (pix_col == COL_FIRST);
        pix_eol   = (pix_col == COL_LAST);
        pix_eof   = pix_eol && (pix_row == ROW_LAST);
    end

    // Raster counters advance only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_in) begin
            col_cnt <= next_col;
            row_cnt <= next_row;
        end
    end

    // Stage 1 holds the accepted pixel and its flags while the line memories are being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_qual  <= 1'b0;
            s1_first <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_col   <= '0;
            s1_pix   <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_qual  <= pix_qual;
                s1_first <= pix_first;
                s1_eol   <= pix_eol;
                s1_eof   <= pix_eof;
                s1_col   <= pix_col;
                s1_pix   <= din;
            end
        end
    end

    // Line j is written one cycle after its read, so each line shifts its old word one line deeper.
    for (genvar j = 0; j < K - 1; j++) begin : g_line
        logic [PW-1:0] wr_data;
        if (j == 0) begin : g_head
            assign wr_data = s1_pix;
        end else begin : g_tail
            assign wr_data = ram_q[j-1];
        end
        line_ram #(
            .DEPTH (COL_NUM),
            .WIDTH (PW)
        ) u_line_ram (
            .clk     (clk),
            .wr_en   (s1_valid),
            .wr_addr (s1_col),
            .wr_data (wr_data),
            .rd_en   (valid_in),
            .rd_addr (pix_col),
            .rd_data (ram_q[j])
        );
    end

    // New tap column, oldest row first: deepest line memory on top, the fresh pixel at the bottom.
    always_comb begin
        col_vec[K-1] = s1_pix;
        for (int r = 0; r < K - 1; r++) begin
            col_vec[r] = ram_q[K-2-r];
        end
    end

    // Stage 2: the tap register shifts left one column per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_eol   <= 1'b0;
            s2_eof   <= 1'b0;
            tap      <= '0;
        end else begin
            s2_valid <= s1_valid && s1_qual;
            if (s1_valid) begin
                s2_first <= s1_first;
                s2_eol   <= s1_eol;
                s2_eof   <= s1_eof;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        tap[tap_lsb(r, c, K, CH, WIDTH) +: PW] <= tap[tap_lsb(r, c + 1, K, CH, WIDTH) +: PW];
                    end
                    tap[tap_lsb(r, K - 1, K, CH, WIDTH) +: PW] <= col_vec[r];
                end
            end
        end
    end

    // Output register: loads only qualified windows and otherwise holds the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_sof   <= 1'b0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            win_valid <= s2_valid;
            if (s2_valid) begin
                win_data <= tap;
                win_sof  <= s2_first;
                win_eol  <= s2_eol;
                win_eof  <= s2_eof;
            end
        end
    end

endmodule

// File: tb/tb_window_kxk_gen.sv
// Bench for window_kxk_gen: two configurations, a raster model of each frame and a scoreboard.
module tb_window_kxk_gen;

    localparam int W      = 8;
    localparam int A_COLS = 8;
    localparam int A_ROWS = 6;
    localparam int A_K    = 3;
    localparam int A_CH   = 1;
    localparam int B_COLS = 16;
    localparam int B_ROWS = 8;
    localparam int B_K    = 5;
    localparam int B_CH   = 3;
    localparam int MAXW   = B_K * B_K * B_CH * W;

    typedef struct {
        logic [MAXW-1:0] data;
        logic            s;
        logic            l;
        logic            f;
        longint          stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic                          valid_a = 1'b0, sof_a = 1'b0;
    logic [A_CH*W-1:0]             din_a = '0;
    logic                          win_valid_a, win_sof_a, win_eol_a, win_eof_a;
    logic [A_K*A_K*A_CH*W-1:0]     win_data_a;

    logic                          valid_b = 1'b0, sof_b = 1'b0;
    logic [B_CH*W-1:0]             din_b = '0;
    logic                          win_valid_b, win_sof_b, win_eol_b, win_eof_b;
    logic [B_K*B_K*B_CH*W-1:0]     win_data_b;

    exp_t            q_a[$];
    exp_t            q_b[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    longint          cyc      = 0;
    logic [23:0]     img [2][16][16];
    int              mrow [2] = '{0, 0};
    int              mcol [2] = '{0, 0};
    int              cnt_win [2] = '{0, 0};
    int              cnt_sof [2] = '{0, 0};
    int              cnt_eol [2] = '{0, 0};
    int              cnt_eof [2] = '{0, 0};
    int              base_win [2] = '{0, 0};
    int              base_sof [2] = '{0, 0};
    int              base_eol [2] = '{0, 0};
    int              base_eof [2] = '{0, 0};
    logic [MAXW-1:0] last_data [2] = '{'0, '0};
    logic [2:0]      last_mk [2] = '{3'b000, 3'b000};
    logic [MAXW-1:0] first_data [2] = '{'0, '0};

    window_kxk_gen #(
        .WIDTH (W), .CH (A_CH), .K (A_K), .COL_NUM (A_COLS), .ROW_NUM (A_ROWS)
    ) u_dut_a (
        .clk (clk), .rst (rst), .valid_in (valid_a), .sof (sof_a), .din (din_a),
        .win_valid (win_valid_a), .win_data (win_data_a),
        .win_sof (win_sof_a), .win_eol (win_eol_a), .win_eof (win_eof_a)
    );

    window_kxk_gen #(
        .WIDTH (W), .CH (B_CH), .K (B_K), .COL_NUM (B_COLS), .ROW_NUM (B_ROWS)
    ) u_dut_b (
        .clk (clk), .rst (rst), .valid_in (valid_b), .sof (sof_b), .din (din_b),
        .win_valid (win_valid_b), .win_data (win_data_b),
        .win_sof (win_sof_b), .win_eol (win_eol_b), .win_eof (win_eof_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Window built straight from the frame image: rows r-K+1..r, columns c-K+1..c.
    function automatic logic [MAXW-1:0] model_window(input int inst, input int r, input int c);
        logic [MAXW-1:0] w;
        int k;
        int pw;
        w  = '0;
        k  = (inst == 0) ? A_K : B_K;
        pw = (inst == 0) ? A_CH * W : B_CH * W;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                for (int b = 0; b < pw; b++) begin
                    w[((i * k) + j) * pw + b] = img[inst][r - k + 1 + i][c - k + 1 + j][b];
                end
            end
        end
        return w;
    endfunction

    function automatic logic [23:0] pix_val(input int inst, input int kind, input int r, input int c);
        logic [7:0] v;
        v = 8'((r * 16) + c);
        if (kind == 2) v = v ^ 8'h80;
        if (kind == 1) return 24'($urandom);
        if (inst == 0) return {16'h0, v};
        return {v ^ 8'h80, v ^ 8'h40, v};
    endfunction

    // Drive one pixel (after optional random idle cycles) and record the window it must produce.
    task automatic apply_stimulus(input int inst, input logic s, input logic [23:0] val, input int idle_pct);
        exp_t e;
        int   k, cols, rows, r, c;
        k    = (inst == 0) ? A_K : B_K;
        cols = (inst == 0) ? A_COLS : B_COLS;
        rows = (inst == 0) ? A_ROWS : B_ROWS;
        while (int'($urandom_range(99, 0)) < idle_pct) begin
            @(posedge clk);
            #1;
        end
        if (inst == 0) begin
            valid_a = 1'b1; sof_a = s; din_a = val[7:0];
        end else begin
            valid_b = 1'b1; sof_b = s; din_b = val;
        end
        @(posedge clk);
        #1;
        valid_a = 1'b0; sof_a = 1'b0;
        valid_b = 1'b0; sof_b = 1'b0;
        if (s) begin
            mrow[inst] = 0;
            mcol[inst] = 0;
        end
        r = mrow[inst];
        c = mcol[inst];
        img[inst][r][c] = val;
        if (r >= k - 1 && c >= k - 1) begin
            e.data  = model_window(inst, r, c);
            e.s     = (r == k - 1) && (c == k - 1);
            e.l     = (c == cols - 1);
            e.f     = (c == cols - 1) && (r == rows - 1);
            e.stamp = cyc + 2;
            if (inst == 0) q_a.push_back(e);
            else           q_b.push_back(e);
        end
        mcol[inst] = c + 1;
        if (mcol[inst] == cols) begin
            mcol[inst] = 0;
            mrow[inst] = (r + 1) % rows;
        end
    endtask

    task automatic send_pixels(input int inst, input int kind, input bit sof_first, input int idle_pct, input int n);
        int r, c;
        bit s;
        for (int i = 0; i < n; i++) begin
            s = sof_first && (i == 0);
            r = s ? 0 : mrow[inst];
            c = s ? 0 : mcol[inst];
            apply_stimulus(inst, s, pix_val(inst, kind, r, c), idle_pct);
        end
    endtask

    // Pop and compare on every presented window; between windows the outputs must hold.
    task automatic check_output(input int inst, input logic v, input logic [MAXW-1:0] data,
                                input logic s, input logic l, input logic f);
        exp_t e;
        int   depth;
        depth = (inst == 0) ? q_a.size() : q_b.size();
        if (v) begin
            cnt_win[inst]++;
            if (s) cnt_sof[inst]++;
            if (l) cnt_eol[inst]++;
            if (f) cnt_eof[inst]++;
            if (depth == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_window dut%0d: got valid=1, want no window", inst);
            end else begin
                if (inst == 0) e = q_a.pop_front();
                else           e = q_b.pop_front();
                check_val($sformatf("win_data_dut%0d", inst), data, e.data);
                check_val($sformatf("markers_dut%0d", inst), MAXW'({s, l, f}), MAXW'({e.s, e.l, e.f}));
                check_val($sformatf("latency_dut%0d", inst), MAXW'(cyc), MAXW'(e.stamp));
                last_data[inst] = e.data;
                last_mk[inst]   = {e.s, e.l, e.f};
                if (s) first_data[inst] = data;
            end
        end else begin
            check_val($sformatf("hold_data_dut%0d", inst), data, last_data[inst]);
            check_val($sformatf("hold_markers_dut%0d", inst), MAXW'({s, l, f}), MAXW'(last_mk[inst]));
        end
    endtask

    always @(negedge clk) check_output(0, win_valid_a, MAXW'(win_data_a), win_sof_a, win_eol_a, win_eof_a);
    always @(negedge clk) check_output(1, win_valid_b, MAXW'(win_data_b), win_sof_b, win_eol_b, win_eof_b);

    task automatic drain_and_count(input int inst, input string tag, input int w, input int s, input int l, input int f);
        repeat (5) @(negedge clk);
        check_int({tag, "_queue_left"}, (inst == 0) ? q_a.size() : q_b.size(), 0);
        check_int({tag, "_windows"}, cnt_win[inst] - base_win[inst], w);
        check_int({tag, "_sof_pulses"}, cnt_sof[inst] - base_sof[inst], s);
        check_int({tag, "_eol_pulses"}, cnt_eol[inst] - base_eol[inst], l);
        check_int({tag, "_eof_pulses"}, cnt_eof[inst] - base_eof[inst], f);
        base_win[inst] = cnt_win[inst];
        base_sof[inst] = cnt_sof[inst];
        base_eol[inst] = cnt_eol[inst];
        base_eof[inst] = cnt_eof[inst];
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid_a"}, MAXW'(win_valid_a), '0);
        check_val({tag, "_data_a"}, MAXW'(win_data_a), '0);
        check_val({tag, "_markers_a"}, MAXW'({win_sof_a, win_eol_a, win_eof_a}), '0);
        check_val({tag, "_valid_b"}, MAXW'(win_valid_b), '0);
        check_val({tag, "_data_b"}, win_data_b, '0);
        check_val({tag, "_markers_b"}, MAXW'({win_sof_b, win_eol_b, win_eof_b}), '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, want completion within 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [MAXW-1:0] first_a_exp;
        logic [MAXW-1:0] fb;
        first_a_exp = MAXW'(72'h22_21_20_12_11_10_02_01_00);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;

        $display("[TB] continuous frame");
        send_pixels(0, 0, 1'b1, 0, A_COLS * A_ROWS);
        drain_and_count(0, "continuous", 24, 1, 4, 1);
        check_val("first_window_taps", first_data[0], first_a_exp);

        $display("[TB] frame with random idle gaps");
        send_pixels(0, 0, 1'b1, 30, A_COLS * A_ROWS);
        drain_and_count(0, "gapped", 24, 1, 4, 1);

        $display("[TB] sof at pixel (3,4)");
        send_pixels(0, 0, 1'b1, 0, 3 * A_COLS + 4);
        send_pixels(0, 2, 1'b1, 0, A_COLS * A_ROWS);
        drain_and_count(0, "resync", 32, 2, 5, 1);

        $display("[TB] three back-to-back random frames");
        send_pixels(0, 1, 1'b1, 0, 3 * A_COLS * A_ROWS);
        drain_and_count(0, "three_frames", 72, 3, 12, 3);

        $display("[TB] reset pulsed at pixel (4,5)");
        send_pixels(0, 0, 1'b1, 0, 4 * A_COLS + 6);
        @(negedge clk);
        #2 rst = 1'b1;
        q_a.delete();
        q_b.delete();
        mrow = '{0, 0};
        mcol = '{0, 0};
        last_data = '{'0, '0};
        last_mk = '{3'b000, 3'b000};
        first_data[0] = '0;
        #2 check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        drain_and_count(0, "before_reset", 14, 1, 2, 0);
        send_pixels(0, 0, 1'b0, 0, A_COLS * A_ROWS);
        drain_and_count(0, "after_reset", 24, 1, 4, 1);
        check_val("after_reset_first_taps", first_data[0], first_a_exp);

        $display("[TB] CH=3 K=5 frame");
        send_pixels(1, 0, 1'b1, 10, B_COLS * B_ROWS);
        drain_and_count(1, "rgb_k5", 48, 1, 4, 1);
        fb = first_data[1];
        check_val("rgb_tap_0_0", MAXW'(fb[23:0]), MAXW'(24'h80_40_00));
        check_val("rgb_tap_4_4", MAXW'(fb[599:576]), MAXW'(24'hC4_04_44));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
